// File: rtl/eclk_bus_sync.sv
`default_nettype none
// ============================================================================
// Module : eclk_bus_sync
// Brief  : E-clock aligned peripheral bus cycle sequencer (VMA, E strobe, ack)
// Rev    : 1.0
// ============================================================================
module eclk_bus_sync #(
  parameter int DATA_W    = 8,
  parameter int VMA_PHASE = 3,
  parameter int STB_PHASE = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        eclk,
  input  logic              req,
  input  logic              sel,
  input  logic              rw,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ack,
  output logic              busy,
  output logic              vma,
  output logic              e_stb,
  output logic              p_rw,
  output logic [DATA_W-1:0] p_wdata,
  input  logic [DATA_W-1:0] p_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t state;

  // Only a few phase taps are used; fold the rest so every input bit is consumed.
  logic eclk_unused;
  assign eclk_unused = ^eclk;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      vma       <= 1'b0;
      e_stb     <= 1'b0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      p_rw      <= 1'b0;
      p_wdata   <= '0;
      cpu_rdata <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req && sel) begin
            p_rw    <= rw;
            p_wdata <= cpu_wdata;
            busy    <= 1'b1;
            state   <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (!req) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (eclk[VMA_PHASE]) begin
            vma   <= 1'b1;
            state <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          // Once the strobe is up the access is committed and must finish at edge 9.
          if (!req && !e_stb) begin
            vma   <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (eclk[9]) begin
            if (p_rw) begin
              cpu_rdata <= p_rdata;
            end
            vma   <= 1'b0;
            e_stb <= 1'b0;
            if (req) begin
              ack   <= 1'b1;
              state <= ST_DONE;
            end else begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end else if (eclk[STB_PHASE]) begin
            e_stb <= 1'b1;
          end
        end

        ST_DONE: begin
          // Hold here until the request is released so one request yields one access.
          if (!req) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_eclk_bus_sync.sv
`default_nettype none
// ============================================================================
// Module : tb_eclk_bus_sync
// Brief  : Randomized self-checking bench for eclk_bus_sync with timeline model
// Rev    : 1.0
// ============================================================================
module tb_eclk_bus_sync;

  localparam int DATA_W    = 8;
  localparam int VMA_PHASE = 3;
  localparam int STB_PHASE = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic [9:0]        eclk;
  logic              req;
  logic              sel;
  logic              rw;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ack;
  logic              busy;
  logic              vma;
  logic              e_stb;
  logic              p_rw;
  logic [DATA_W-1:0] p_wdata;
  logic [DATA_W-1:0] p_rdata;

  always #5 clk = ~clk;

  eclk_bus_sync #(
    .DATA_W   (DATA_W),
    .VMA_PHASE(VMA_PHASE),
    .STB_PHASE(STB_PHASE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .eclk     (eclk),
    .req      (req),
    .sel      (sel),
    .rw       (rw),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .ack      (ack),
    .busy     (busy),
    .vma      (vma),
    .e_stb    (e_stb),
    .p_rw     (p_rw),
    .p_wdata  (p_wdata),
    .p_rdata  (p_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ph       = 0;
  bit fix_rdata = 1'b0;

  // Reference: each access is a timeline of absolute edge numbers.
  int edge_n = 0;
  bit m_tx = 1'b0, m_done = 1'b0;
  int t_vma = 0, t_stb = 0, t_end = 0;
  logic m_vma = 1'b0, m_stb = 1'b0, m_ack = 1'b0, m_busy = 1'b0, m_prw = 1'b0;
  logic [DATA_W-1:0] m_pwdata = '0, m_rdata = '0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies the rules to the inputs the DUT will sample on the coming edge.
  task automatic model_edge();
    int d;
    edge_n++;
    m_ack = 1'b0;
    if (reset) begin
      m_tx = 0; m_done = 0;
      m_busy = 0; m_prw = 0; m_pwdata = '0; m_rdata = '0;
    end else if (m_tx) begin
      if (!req && edge_n <= t_stb) begin
        m_tx = 0; m_busy = 0;
      end else if (edge_n == t_end) begin
        m_tx = 0;
        if (m_prw) m_rdata = p_rdata;
        if (req) begin
          m_ack = 1; m_done = 1;
        end else begin
          m_busy = 0;
        end
      end
    end else if (m_done) begin
      if (!req) begin
        m_done = 0; m_busy = 0;
      end
    end else if (req && sel) begin
      m_tx = 1; m_busy = 1; m_prw = rw; m_pwdata = cpu_wdata;
      d = (VMA_PHASE - ph + 10) % 10;
      if (d == 0) d = 10;
      t_vma = edge_n + d;
      t_stb = t_vma + (STB_PHASE - VMA_PHASE);
      t_end = t_vma + (9 - VMA_PHASE);
    end
    m_vma = m_tx && (edge_n >= t_vma);
    m_stb = m_tx && (edge_n >= t_stb);
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
    check_val("vma", vma, m_vma);
    check_val("e_stb", e_stb, m_stb);
    check_val("ack", ack, m_ack);
    check_val("busy", busy, m_busy);
    check_val("p_rw", p_rw, m_prw);
    check_val("p_wdata", p_wdata, m_pwdata);
    check_val("cpu_rdata", cpu_rdata, m_rdata);
    check_val("ack_vma_excl", ack & vma, 0);
    ph   = (ph + 1) % 10;
    eclk = 10'(1) << ph;
    if (!fix_rdata) p_rdata = DATA_W'($urandom);
  endtask

  task automatic wait_phase(input int k);
    for (int i = 0; i < 10 && ph != k; i++) step();
  endtask

  task automatic run_access(input int sph, input logic r, input logic [DATA_W-1:0] wd,
                            input int drop_ph, input int hold);
    int held;
    bit fin;
    held = 0;
    fin  = 1'b0;
    req  = 1'($urandom);
    sel  = 1'b0;
    wait_phase(sph);
    req = 1'b1; sel = 1'b1; rw = r; cpu_wdata = wd;
    for (int i = 0; i < 80 && !fin; i++) begin
      step();
      sel = 1'($urandom); rw = 1'($urandom); cpu_wdata = DATA_W'($urandom);
      if (drop_ph >= 0 && m_vma && ph == drop_ph) req = 1'b0;
      if (m_done) begin
        held++;
        if (held > hold) req = 1'b0;
      end
      if (!m_tx && !m_done && req == 1'b0) fin = 1'b1;
    end
    check_val("access_timeout", 32'(fin), 1);
    req = 1'b0;
    step();
  endtask

  always @(negedge clk) begin
    assert ($onehot(eclk)) else $error("eclk not one-hot");
  end

  initial begin
    reset = 1'b1; req = 1'b0; sel = 1'b0; rw = 1'b0;
    cpu_wdata = '0; p_rdata = '0; eclk = 10'b1; ph = 0;
    repeat (3) step();
    reset = 1'b0;
    step();

    // Reset during the strobe window of a read.
    wait_phase(0);
    req = 1'b1; sel = 1'b1; rw = 1'b1;
    for (int i = 0; i < 20 && ph != 7; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0; req = 1'b0;
    check_val("rst_busy", busy, 0);
    check_val("rst_rdata", cpu_rdata, 0);
    step();

    fix_rdata = 1'b1;
    p_rdata   = 8'hA5;
    run_access(0, 1'b1, 8'h00, -1, 2);
    check_val("read_a5", cpu_rdata, 8'hA5);
    fix_rdata = 1'b0;

    run_access(3, 1'b1, DATA_W'($urandom), -1, 0);
    run_access(0, 1'b0, 8'h3C, -1, 1);
    run_access(0, 1'b1, DATA_W'($urandom), 4, 0);
    run_access(0, 1'b1, DATA_W'($urandom), 7, 0);
    run_access(1, 1'b1, DATA_W'($urandom), -1, 30);

    for (int n = 0; n < 25; n++) begin
      run_access(int'($urandom % 10), 1'($urandom), DATA_W'($urandom),
                 ($urandom % 3 == 0) ? int'($urandom % 10) : -1, int'($urandom % 4));
    end

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eclk_bus_sync.md
Name: eclk_bus_sync

Overview:
- Synchronous-peripheral (6800-style E-clock) bus cycle sequencer for the CIA path.
- Consumes the one-hot 10-phase E-clock enable vector and the 7 MHz `clk` from the clock generator.
- Turns a CPU peripheral request (VPA-style select) into an E-aligned access with VMA, an E-high strobe and read-data capture.
- Returns a one-cycle acknowledge to the CPU-side bus logic.

Parameters:
- DATA_W, 8, width of the peripheral data bus.
- VMA_PHASE, 3, E phase whose ending edge raises `vma`. Must be < STB_PHASE.
- STB_PHASE, 5, E phase whose ending edge raises `e_stb`. Must be < 9.

Ports:
- clk  in  1  7.09 MHz system clock. All logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- eclk  in  10  one-hot E phase; `eclk[k]`=1 during phase k (0..9), free-running.
- req  in  1  CPU access request, held until `ack` or abandoned.
- sel  in  1  peripheral (VPA) select, qualifies `req`.
- rw  in  1  1=read, 0=write. Latched at request accept.
- cpu_wdata  in  DATA_W  write data. Latched at request accept.
- cpu_rdata  out  DATA_W  captured read data.
- ack  out  1  one-cycle cycle-complete pulse.
- busy  out  1  sequencer not idle.
- vma  out  1  valid memory address to peripheral.
- e_stb  out  1  peripheral access strobe (E-high window).
- p_rw  out  1  latched `rw` to peripheral.
- p_wdata  out  DATA_W  latched write data to peripheral.
- p_rdata  in  DATA_W  peripheral read data.

Behaviour:
- General rules:
  - All outputs are registered.
  - "Edge k" means the rising `clk` edge that ends the cycle in which `eclk[k]`=1.
- Reset:
  - state=IDLE.
  - `vma`, `e_stb`, `ack`, `busy`, `p_rw`, `p_wdata`, `cpu_rdata` all = 0.
  - Reset mid-cycle drops `vma`, `e_stb`, `ack` on that edge. No data capture, no `ack`.
- States: IDLE, WAIT, ACTIVE, DONE.
- IDLE:
  - On any edge with `req`&`sel`: latch `rw`→`p_rw` and `cpu_wdata`→`p_wdata`; `busy`<=1; go to WAIT.
- WAIT:
  - At edge VMA_PHASE: `vma`<=1, go to ACTIVE.
  - A request accepted on edge VMA_PHASE itself waits for the next occurrence, 10 clocks later.
- ACTIVE:
  - At edge STB_PHASE: `e_stb`<=1.
  - At edge 9:
    - If `p_rw`: `cpu_rdata`<=`p_rdata`.
    - `vma`<=0, `e_stb`<=0.
    - `ack`<=1 if `req` is still high, otherwise go straight to IDLE.
    - Otherwise go to DONE.
  - Default timing: `vma` high during phases 4..9; `e_stb` high during phases 6..9.
- DONE:
  - `ack` is forced to 0 after one cycle.
  - Stay until `req`=0, then go to IDLE with `busy`<=0.
  - This prevents a double access on a held request.
- Abort:
  - `req`=0 in WAIT, or in ACTIVE before edge STB_PHASE → IDLE next edge. `vma`<=0, no strobe, no `ack`.
  - `req`=0 after `e_stb` has risen → the cycle runs to edge 9 (access committed), no `ack`, then IDLE.
- Other rules:
  - `sel` is only sampled in IDLE.
  - `cpu_rdata` holds its value between reads and is unchanged by writes.
  - `ack` and `vma` are never high in the same cycle.
  - Assertion check: `eclk` is not one-hot.
    - Behaviour is undefined in that case; it is flagged by the bench only.

Test Plan:
- Read, request accepted on edge 0:
  - `vma` rises after edge 3 (3 edges later).
  - `e_stb` high phases 6..9.
  - With `p_rdata`=0xA5: `cpu_rdata`=0xA5 and `ack`=1 for exactly one cycle after edge 9 (9 edges after accept); `busy` drops once `req` falls.
- Request accepted on edge 3:
  - `vma` rises after the next edge 3 (10 edges later).
  - `ack` comes 16 edges after accept.
- Write, `cpu_wdata`=0x3C, `rw`=0:
  - `p_wdata`=0x3C and `p_rw`=0 from accept through edge 9.
  - `cpu_rdata` keeps its prior value; `ack` pulses once.
- Abort:
  - `req` dropped in phase 4 → `vma` low after edge 4, `e_stb` never high, no `ack`.
  - `req` dropped in phase 7 → `e_stb` completes through phase 9, no `ack`, `busy` low after edge 9.
- `req` held high for 30 cycles after `ack` → exactly one `ack`, no second `vma`.
- `reset` asserted in phase 7 of an active read → `vma`, `e_stb` and `busy` are 0 next cycle, `cpu_rdata` stays 0, no `ack`.
